load_align_extend: RTL and testbench

Registered load-data alignment and extension unit between the Data Memory read port and the register-file write-back path. It takes a full memory word, a byte offset, an access size and a signed/unsigned flag. It extracts the addressed byte, halfword or word and sign- or zero-extends it to the full datapath width. A valid/ready handshake with a one-entry skid buffer gives one cycle of latency and full throughput, and misaligned or illegal accesses are flagged.

---
 rtl/load_align_extend.sv | 153 +++++++++++++++
 tb/tb_load_align_extend.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/load_align_extend.sv
// load_align_extend
//   Registered load-data aligner between the data-memory read port and
//   register-file write-back. Extracts the addressed byte/halfword/word/
//   doubleword, sign- or zero-extends it to DATA_W, and flags misaligned or
//   illegal accesses. A one-entry skid buffer behind the output register
//   gives one cycle of latency at full throughput. in_ready is driven only
//   from registered state and reset, never from out_ready.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       request handshake
//   in_data [DATA_W]        raw memory word
//   in_offset [OFF_W]       byte offset of the access (byte 0 = bits [7:0])
//   in_size [2]             0 byte, 1 half, 2 word, 3 double (DATA_W=64 only)
//   in_signed               1 sign-extend, 0 zero-extend
//   out_valid/out_ready     result handshake
//   out_data [DATA_W]       aligned, extended result (0 on error)
//   out_err                 misaligned or illegal access
//
// Occupancy FSM
//   state | meaning
//   EMPTY | no result held
//   ONE   | output register holds a result
//   FULL  | output register and skid register both hold results
module load_align_extend #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  // Bit 0 marks the output register occupied, bit 1 the skid register, so
  // out_valid and skid_valid are straight flop outputs.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } occ_e;

  occ_e              state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_err_q, out_err_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_err_q, skid_err_d;

  logic              skid_valid;
  logic              accept, drain;
  logic [DATA_W-1:0] shifted, ext, res_data;
  logic              misalign, illegal, res_err;

  assign out_valid  = state_q[0];
  assign skid_valid = state_q[1];
  assign in_ready   = ~skid_valid & ~reset;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Alignment and extension of the incoming request.
  always_comb begin
    shifted  = in_data >> {in_offset, 3'b000};
    ext      = shifted;
    misalign = 1'b0;
    case (in_size)
      2'd0: begin
        misalign = 1'b0;
        ext = in_signed ? DATA_W'($signed(shifted[7:0])) : DATA_W'(shifted[7:0]);
      end
      2'd1: begin
        misalign = in_offset[0];
        ext = in_signed ? DATA_W'($signed(shifted[15:0])) : DATA_W'(shifted[15:0]);
      end
      2'd2: begin
        misalign = |in_offset[1:0];
        ext = in_signed ? DATA_W'($signed(shifted[31:0])) : DATA_W'(shifted[31:0]);
      end
      default: begin
        misalign = |in_offset;
        ext      = shifted;
      end
    endcase
    illegal  = (in_size == 2'd3) && (DATA_W < 64);
    res_err  = misalign | illegal;
    res_data = res_err ? '0 : ext;
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_data_d = res_data;
          out_err_d  = res_err;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          out_data_d = res_data;
          out_err_d  = res_err;
        end else if (accept) begin
          skid_data_d = res_data;
          skid_err_d  = res_err;
          state_d     = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so no accept can coincide with this drain.
        if (drain) begin
          out_data_d = skid_data_q;
          out_err_d  = skid_err_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
    end
  end

endmodule

// File: tb/tb_load_align_extend.sv
module tb_load_align_extend;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready, out_err;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_offset, in_size;

  logic        in_valid_64, in_ready_64, in_signed_64, out_valid_64, out_ready_64, out_err_64;
  logic [63:0] in_data_64, out_data_64;
  logic [2:0]  in_offset_64;
  logic [1:0]  in_size_64;

  int total = 0;
  int bad   = 0;
  logic [64:0] q[$];   // {err, data} of accepted, not yet drained results

  always #5 clk = ~clk;

  load_align_extend #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_offset(in_offset), .in_size(in_size), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  load_align_extend #(.DATA_W(64)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_64), .in_ready(in_ready_64), .in_data(in_data_64),
    .in_offset(in_offset_64), .in_size(in_size_64), .in_signed(in_signed_64),
    .out_valid(out_valid_64), .out_ready(out_ready_64), .out_data(out_data_64), .out_err(out_err_64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: field of width 8<<size at byte offset, extended to dw bits.
  function automatic logic [64:0] ref_calc(input int dw, input logic [63:0] d,
                                           input int off, input int sz, input bit sg);
    int w;
    logic [127:0] f, mask;
    w = 8 << sz;
    if (w > dw || (off % (w / 8)) != 0) return {1'b1, 64'd0};
    mask = (128'd1 << w) - 128'd1;
    f = ({64'd0, d} >> (off * 8)) & mask;
    if (sg && w < dw && f[w-1]) f = f | ~mask;
    f = f & ((128'd1 << dw) - 128'd1);
    return {1'b0, f[63:0]};
  endfunction

  // One clock: drive at posedge+1, observe at negedge, scoreboard accept/drain.
  task automatic step(input bit v, input logic [31:0] d, input logic [1:0] off,
                      input logic [1:0] sz, input bit sg, input bit ordy);
    logic [64:0] e;
    in_valid = v; in_data = d; in_offset = off; in_size = sz; in_signed = sg;
    out_ready = ordy;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (out_valid && out_ready && q.size() > 0) begin
      e = q.pop_front();
      chk("out_data", 64'(out_data), e[63:0]);
      chk("out_err", 64'(out_err), 64'(e[64]));
    end
    if (in_valid && in_ready)
      q.push_back(ref_calc(32, 64'(d), int'(off), int'(sz), sg));
    @(posedge clk); #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] d, input logic [1:0] off,
                          input logic [1:0] sz, input bit sg,
                          input logic [31:0] exp_d, input bit exp_e);
    step(1'b1, d, off, sz, sg, 1'b1);
    chk({tag, "_data"}, 64'(out_data), 64'(exp_d));
    chk({tag, "_err"}, 64'(out_err), 64'(exp_e));
    step(1'b0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_offset = 2'd0; in_size = 2'd0;
    in_signed = 1'b1; out_ready = 1'b1;
    in_valid_64 = 1'b0; in_data_64 = '0; in_offset_64 = '0; in_size_64 = '0;
    in_signed_64 = 1'b0; out_ready_64 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    directed("b_s0",   32'h1234_5680, 2'd0, 2'd0, 1'b1, 32'hFFFF_FF80, 1'b0);
    directed("b_u0",   32'h1234_5680, 2'd0, 2'd0, 1'b0, 32'h0000_0080, 1'b0);
    directed("b_s3",   32'h1234_5680, 2'd3, 2'd0, 1'b1, 32'h0000_0012, 1'b0);
    directed("h_s2",   32'h8001_0000, 2'd2, 2'd1, 1'b1, 32'hFFFF_8001, 1'b0);
    directed("h_u2",   32'h8001_0000, 2'd2, 2'd1, 1'b0, 32'h0000_8001, 1'b0);
    directed("h_s0",   32'h8001_0000, 2'd0, 2'd1, 1'b1, 32'h0000_0000, 1'b0);
    directed("h_mis",  32'h8001_0000, 2'd1, 2'd1, 1'b1, 32'h0000_0000, 1'b1);
    directed("d_ill",  32'h8001_0000, 2'd0, 2'd3, 1'b0, 32'h0000_0000, 1'b1);
    directed("w_pass", 32'h8001_0000, 2'd0, 2'd2, 1'b1, 32'h8001_0000, 1'b0);
    directed("w_mis",  32'h8001_0000, 2'd2, 2'd2, 1'b0, 32'h0000_0000, 1'b1);

    // Backpressure: A, B accepted, C held until space frees up.
    step(1'b1, 32'h0000_00A1, 2'd0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_B200, 2'd1, 2'd0, 1'b0, 1'b0);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    step(1'b1, 32'h00C3_0000, 2'd2, 2'd0, 1'b0, 1'b0);
    step(1'b1, 32'h00C3_0000, 2'd2, 2'd0, 1'b0, 1'b0);
    step(1'b1, 32'h00C3_0000, 2'd2, 2'd0, 1'b0, 1'b1);
    step(1'b1, 32'h00C3_0000, 2'd2, 2'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    chk("bp_empty", 64'(q.size()), 64'd0);

    // Sustained throughput: one result every cycle.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom, 2'(i), 2'd0, i[0], 1'b1);
      chk("tput_valid", 64'(out_valid), 64'd1);
    end
    step(1'b0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1);

    // Reset while FULL: both entries vanish.
    step(1'b1, 32'h1111_1111, 2'd0, 2'd2, 1'b0, 1'b0);
    step(1'b1, 32'h2222_2222, 2'd0, 2'd2, 1'b0, 1'b0);
    reset = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_err", 64'(out_err), 64'd0);
    chk("mid_rst_in_ready1", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    repeat (3) step(1'b0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 10 && q.size() > 0; i++)
      step(1'b0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    chk("rand_drained", 64'(q.size()), 64'd0);

    // 64-bit instance.
    in_valid_64 = 1'b1; in_data_64 = 64'h8000_0000_0000_0000; in_offset_64 = 3'd4;
    in_size_64 = 2'd2; in_signed_64 = 1'b1; out_ready_64 = 1'b1;
    @(negedge clk);
    chk("w64_in_ready", 64'(in_ready_64), 64'd1);
    @(posedge clk); #1;
    in_data_64 = 64'hDEAD_BEEF_0123_4567; in_offset_64 = 3'd0; in_size_64 = 2'd3;
    in_signed_64 = 1'b0;
    @(negedge clk);
    chk("w64_word_s", out_data_64, 64'hFFFF_FFFF_8000_0000);
    chk("w64_word_err", 64'(out_err_64), 64'd0);
    @(posedge clk); #1;
    in_offset_64 = 3'd4;
    @(negedge clk);
    chk("w64_dword", out_data_64, 64'hDEAD_BEEF_0123_4567);
    chk("w64_dword_err", 64'(out_err_64), 64'd0);
    @(posedge clk); #1;
    in_data_64 = 64'h0000_0000_FFFF_0000; in_offset_64 = 3'd2; in_size_64 = 2'd1;
    in_signed_64 = 1'b1;
    @(negedge clk);
    chk("w64_dword_mis", out_data_64, 64'd0);
    chk("w64_dword_mis_err", 64'(out_err_64), 64'd1);
    @(posedge clk); #1;
    in_valid_64 = 1'b0;
    @(negedge clk);
    chk("w64_half_s", out_data_64, ref_calc(64, 64'h0000_0000_FFFF_0000, 2, 1, 1'b1));
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
